// File: rtl/player_ctrl_grid.sv
// player_ctrl_grid: tile-grid player controller with press capture, timed sword, cooldown and respawn/freeze hooks.
// Define PLAYER_AUTOREPEAT_EN to make a held direction repeat its move every REPEAT_TICKS ticks while idle.
module player_ctrl_grid #(
  parameter int X_BITS         = 4,
  parameter int Y_BITS         = 4,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 15,
  parameter int Y_MIN          = 1,
  parameter int Y_MAX          = 11,
  parameter logic [X_BITS+Y_BITS-1:0] START_POS = 8'h13,
  parameter int ATTACK_TICKS   = 2,
  parameter int COOLDOWN_TICKS = 1,
  parameter int ANIM_TICKS     = 21,
  parameter int REPEAT_TICKS   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trigger,
  input  logic [4:0]               buttons,
  input  logic                     freeze,
  input  logic                     respawn,
  output logic [X_BITS+Y_BITS-1:0] player_pos,
  output logic [1:0]               player_orientation,
  output logic [1:0]               player_direction,
  output logic [3:0]               player_sprite,
  output logic [X_BITS+Y_BITS-1:0] sword_position,
  output logic                     sword_visible,
  output logic [1:0]               sword_orientation,
  output logic                     busy
);

  localparam int PW = X_BITS + Y_BITS;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam int AW = (ATTACK_TICKS < 2) ? 1 : $clog2(ATTACK_TICKS);
  localparam int CW = (COOLDOWN_TICKS < 2) ? 1 : $clog2(COOLDOWN_TICKS);
  localparam int NW = $clog2(ANIM_TICKS);

  localparam logic [AW-1:0] ATK_LAST  = AW'(ATTACK_TICKS - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);
  localparam logic [NW-1:0] ANIM_LAST = NW'(ANIM_TICKS - 1);
  localparam logic [NW-1:0] ANIM_HALF = NW'(ANIM_TICKS / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ATTACK,
    S_COOLDOWN
  } state_t;

  typedef struct packed {
    logic          ok;
    logic [PW-1:0] pos;
  } step_t;

  // One-cell neighbour in a direction; each field is computed separately so x and y never carry into each other.
  function automatic step_t step(input logic [PW-1:0] pos, input logic [1:0] dir);
    int    x;
    int    y;
    step_t r;
    x = int'(pos[PW-1:Y_BITS]);
    y = int'(pos[Y_BITS-1:0]);
    case (dir)
      DIR_UP:    y = y - 1;
      DIR_RIGHT: x = x + 1;
      DIR_DOWN:  y = y + 1;
      default:   x = x - 1;
    endcase
    r.ok  = (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
    r.pos = {X_BITS'(x), Y_BITS'(y)};
    return r;
  endfunction

  // Winning direction among {right,left,down,up} bits, priority up > down > left > right; MSB flags validity.
  function automatic logic [2:0] pick_dir(input logic [3:0] d);
    if (d[0])      return {1'b1, DIR_UP};
    else if (d[1]) return {1'b1, DIR_DOWN};
    else if (d[2]) return {1'b1, DIR_LEFT};
    else if (d[3]) return {1'b1, DIR_RIGHT};
    else           return {1'b0, DIR_UP};
  endfunction

  state_t        state;
  logic [4:0]    btn_q;
  logic [4:0]    press_q;
  logic [4:0]    rise;
  logic [4:0]    pend;
  logic [2:0]    pend_pick;
  logic [1:0]    atk_dir;
  step_t         atk_step;
  step_t         mv_step;
  logic [AW-1:0] atk_cnt;
  logic [CW-1:0] cd_cnt;
  logic [NW-1:0] anim_cnt;

  // A rising edge on the tick clock itself still belongs to the presses evaluated on that tick.
  assign rise      = buttons & ~btn_q;
  assign pend      = press_q | rise;
  assign pend_pick = pick_dir(pend[3:0]);
  assign atk_dir   = pend_pick[2] ? pend_pick[1:0] : player_direction;
  assign atk_step  = step(player_pos, atk_dir);
  assign mv_step   = step(player_pos, pend_pick[1:0]);

  assign player_sprite = (state == S_ATTACK)   ? 4'b0100 :
                         (anim_cnt < ANIM_HALF) ? 4'b0010 : 4'b0011;

`ifdef PLAYER_AUTOREPEAT_EN
  localparam int RW = (REPEAT_TICKS < 2) ? 1 : $clog2(REPEAT_TICKS);
  localparam logic [RW-1:0] REP_LAST = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  logic          rep_active;
  logic [1:0]    rep_dir;
  logic [RW-1:0] rep_cnt;
  logic [2:0]    held_pick;
  step_t         rep_step;

  assign held_pick = pick_dir(buttons[3:0]);
  assign rep_step  = step(player_pos, rep_dir);
`endif

  // Single controller process: respawn beats freeze, freeze beats tick actions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= S_IDLE;
      player_pos         <= START_POS;
      player_orientation <= DIR_RIGHT;
      player_direction   <= DIR_RIGHT;
      sword_position     <= '0;
      sword_visible      <= 1'b0;
      sword_orientation  <= DIR_RIGHT;
      busy               <= 1'b0;
      btn_q              <= '0;
      press_q            <= '0;
      atk_cnt            <= '0;
      cd_cnt             <= '0;
      anim_cnt           <= '0;
`ifdef PLAYER_AUTOREPEAT_EN
      rep_active         <= 1'b0;
      rep_dir            <= DIR_UP;
      rep_cnt            <= '0;
`endif
    end else begin
      btn_q <= buttons;
      if (respawn) begin
        state          <= S_IDLE;
        player_pos     <= START_POS;
        sword_position <= '0;
        sword_visible  <= 1'b0;
        busy           <= 1'b0;
        press_q        <= '0;
        atk_cnt        <= '0;
        cd_cnt         <= '0;
        anim_cnt       <= '0;
`ifdef PLAYER_AUTOREPEAT_EN
        rep_active     <= 1'b0;
        rep_cnt        <= '0;
`endif
      end else if (freeze) begin
        press_q <= '0;
      end else if (trigger) begin
        press_q  <= '0;
        anim_cnt <= (anim_cnt == ANIM_LAST) ? '0 : anim_cnt + 1'b1;
        unique case (state)
          S_IDLE: begin
            if (pend[4]) begin
              player_direction  <= atk_dir;
              sword_orientation <= atk_dir;
              if (atk_dir[0]) player_orientation <= atk_dir;
              sword_position    <= atk_step.pos;
              sword_visible     <= atk_step.ok;
              atk_cnt           <= '0;
              state             <= S_ATTACK;
              busy              <= 1'b1;
`ifdef PLAYER_AUTOREPEAT_EN
              rep_active        <= 1'b0;
              rep_cnt           <= '0;
`endif
            end else if (pend_pick[2]) begin
              player_direction <= pend_pick[1:0];
              if (pend_pick[0]) player_orientation <= pend_pick[1:0];
              if (mv_step.ok) player_pos <= mv_step.pos;
`ifdef PLAYER_AUTOREPEAT_EN
              rep_active       <= 1'b1;
              rep_dir          <= pend_pick[1:0];
              rep_cnt          <= '0;
`endif
            end
`ifdef PLAYER_AUTOREPEAT_EN
            else if (rep_active && held_pick[2] && (held_pick[1:0] == rep_dir)) begin
              if (rep_cnt == REP_LAST) begin
                rep_cnt <= '0;
                if (rep_step.ok) player_pos <= rep_step.pos;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end else begin
              rep_active <= 1'b0;
              rep_cnt    <= '0;
            end
`endif
          end
          S_ATTACK: begin
            if (atk_cnt == ATK_LAST) begin
              sword_visible  <= 1'b0;
              sword_position <= '0;
              cd_cnt         <= '0;
              if (COOLDOWN_TICKS == 0) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_COOLDOWN;
              end
            end else begin
              atk_cnt <= atk_cnt + 1'b1;
            end
          end
          S_COOLDOWN: begin
            if (cd_cnt == CD_LAST) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              cd_cnt <= cd_cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else begin
        press_q <= press_q | rise;
      end
    end
  end

endmodule

// File: tb/tb_player_ctrl_grid.sv
// Bench for player_ctrl_grid: directed scenarios with literal expectations, then random traffic
// checked every cycle against a tick-level behavioural model of the player.
module tb_player_ctrl_grid;

  localparam int X_MIN          = 0;
  localparam int X_MAX          = 15;
  localparam int Y_MIN          = 1;
  localparam int Y_MAX          = 11;
  localparam int ATTACK_TICKS   = 2;
  localparam int COOLDOWN_TICKS = 1;
  localparam int ANIM_TICKS     = 21;
  localparam int REPEAT_TICKS   = 8;
  localparam logic [7:0] START_POS = 8'h13;

`ifdef PLAYER_AUTOREPEAT_EN
  localparam logic [7:0] AR_END = 8'h16;
`else
  localparam logic [7:0] AR_END = 8'h14;
`endif

  localparam logic [4:0] B_UP    = 5'b00001;
  localparam logic [4:0] B_DOWN  = 5'b00010;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b01000;
  localparam logic [4:0] B_ATK   = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic [4:0] buttons = 5'b0;
  logic       freeze = 1'b0;
  logic       respawn = 1'b0;

  logic [7:0] player_pos;
  logic [1:0] player_orientation;
  logic [1:0] player_direction;
  logic [3:0] player_sprite;
  logic [7:0] sword_position;
  logic       sword_visible;
  logic [1:0] sword_orientation;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  player_ctrl_grid dut (
    .clk               (clk),
    .reset             (reset),
    .trigger           (trigger),
    .buttons           (buttons),
    .freeze            (freeze),
    .respawn           (respawn),
    .player_pos        (player_pos),
    .player_orientation(player_orientation),
    .player_direction  (player_direction),
    .player_sprite     (player_sprite),
    .sword_position    (sword_position),
    .sword_visible     (sword_visible),
    .sword_orientation (sword_orientation),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Model: position as plain ints, the busy period as ticks remaining, animation as ticks since (re)start.
  int         m_x, m_y, m_dir, m_orient, m_sdir, m_sx, m_sy, m_svis;
  int         m_busy_left, m_ticks, m_rep_dir, m_rep_age;
  logic [4:0] m_prev, m_press;

  function automatic int winner(input logic [3:0] d);
    if (d[0]) return 0;
    if (d[1]) return 2;
    if (d[2]) return 3;
    if (d[3]) return 1;
    return -1;
  endfunction

  function automatic int ddx(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int ddy(input int d);
    return (d == 0) ? -1 : (d == 2) ? 1 : 0;
  endfunction

  function automatic bit in_grid(input int x, input int y);
    return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
  endfunction

  task automatic model_home();
    m_x = int'(START_POS >> 4);
    m_y = int'(START_POS & 8'h0F);
    m_svis = 0; m_sx = 0; m_sy = 0;
    m_busy_left = 0; m_ticks = 0; m_press = '0; m_rep_dir = -1; m_rep_age = 0;
  endtask

  task automatic model_init();
    model_home();
    m_dir = 1; m_orient = 1; m_sdir = 1; m_prev = '0;
  endtask

  task automatic try_move(input int d);
    if (in_grid(m_x + ddx(d), m_y + ddy(d))) begin
      m_x = m_x + ddx(d);
      m_y = m_y + ddy(d);
    end
  endtask

  task automatic model_step();
    logic [4:0] rise, pend;
    int w, ad, tx, ty, hw;
    if (!reset) begin
      model_init();
      return;
    end
    rise   = buttons & ~m_prev;
    m_prev = buttons;
    if (respawn) begin
      model_home();
    end else if (freeze) begin
      m_press = '0;
    end else if (trigger) begin
      pend    = m_press | rise;
      m_press = '0;
      m_ticks++;
      w = winner(pend[3:0]);
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == COOLDOWN_TICKS) begin
          m_svis = 0; m_sx = 0; m_sy = 0;
        end
        m_rep_dir = -1;
      end else if (pend[4]) begin
        ad = (w >= 0) ? w : m_dir;
        m_dir = ad; m_sdir = ad;
        if (ad == 1 || ad == 3) m_orient = ad;
        tx = m_x + ddx(ad);
        ty = m_y + ddy(ad);
        m_svis = in_grid(tx, ty) ? 1 : 0;
        m_sx = tx & 15;
        m_sy = ty & 15;
        m_busy_left = ATTACK_TICKS + COOLDOWN_TICKS;
        m_rep_dir = -1;
      end else if (w >= 0) begin
        m_dir = w;
        if (w == 1 || w == 3) m_orient = w;
        try_move(w);
        m_rep_dir = w;
        m_rep_age = 0;
      end else begin
        hw = winner(buttons[3:0]);
`ifdef PLAYER_AUTOREPEAT_EN
        if (m_rep_dir >= 0 && hw == m_rep_dir) begin
          m_rep_age++;
          if (m_rep_age == REPEAT_TICKS) begin
            m_rep_age = 0;
            try_move(m_rep_dir);
          end
        end else begin
          m_rep_dir = -1;
        end
`else
        if (hw != m_rep_dir) m_rep_dir = -1;
`endif
      end
    end else begin
      m_press = m_press | rise;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Cycle-by-cycle comparison against the model, sampled mid-period.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("player_pos",  32'(player_pos), 32'((m_x << 4) | m_y));
      check_output("direction",   32'(player_direction), 32'(m_dir));
      check_output("orientation", 32'(player_orientation), 32'(m_orient));
      check_output("sword_pos",   32'(sword_position), 32'((m_sx << 4) | m_sy));
      check_output("sword_vis",   32'(sword_visible), 32'(m_svis));
      check_output("sword_dir",   32'(sword_orientation), 32'(m_sdir));
      check_output("busy",        32'(busy), 32'(m_busy_left > 0));
      check_output("sprite",      32'(player_sprite),
                   (m_busy_left > COOLDOWN_TICKS) ? 32'd4 :
                   ((m_ticks % ANIM_TICKS) < (ANIM_TICKS / 2)) ? 32'd2 : 32'd3);
    end
  end

  task automatic apply_stimulus(input bit trig, input logic [4:0] btn, input bit frz, input bit rsp);
    trigger = trig;
    buttons = btn;
    freeze  = frz;
    respawn = rsp;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic press_tick(input logic [4:0] mask);
    apply_stimulus(1'b0, mask, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 5'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] rb;
    bit         rf;
    reset = 1'b0;
    apply_stimulus(1'b0, 5'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 5'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    reset  = 1'b1;
    apply_stimulus(1'b0, 5'b0, 1'b0, 1'b0);
    check_output("rst_pos", 32'(player_pos), 32'h13);
    check_output("rst_dir", 32'(player_direction), 32'h1);
    check_output("rst_orient", 32'(player_orientation), 32'h1);
    check_output("rst_sword_vis", 32'(sword_visible), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_sprite", 32'(player_sprite), 32'h2);

    press_tick(B_UP);
    check_output("pulse_up_pos", 32'(player_pos), 32'h12);
    check_output("pulse_up_dir", 32'(player_direction), 32'h0);
    press_tick(B_UP);
    press_tick(B_UP);
    check_output("top_edge_pos", 32'(player_pos), 32'h11);
    press_tick(B_LEFT);
    press_tick(B_UP);
    check_output("corner_up_pos", 32'(player_pos), 32'h01);
    check_output("corner_up_dir", 32'(player_direction), 32'h0);
    for (int i = 0; i < 4; i++) press_tick(B_DOWN);
    for (int i = 0; i < 15; i++) press_tick(B_RIGHT);
    press_tick(B_RIGHT);
    check_output("right_edge_pos", 32'(player_pos), 32'hF5);
    check_output("right_edge_dir", 32'(player_direction), 32'h1);
    for (int i = 0; i < 12; i++) press_tick(B_LEFT);
    check_output("walk_pos", 32'(player_pos), 32'h35);

    press_tick(B_ATK | B_LEFT);
    check_output("atk_sword_pos", 32'(sword_position), 32'h25);
    check_output("atk_sword_vis", 32'(sword_visible), 32'h1);
    check_output("atk_busy", 32'(busy), 32'h1);
    check_output("atk_sprite", 32'(player_sprite), 32'h4);
    press_tick(B_RIGHT);
    check_output("atk_t1_vis", 32'(sword_visible), 32'h1);
    press_tick(B_RIGHT);
    check_output("atk_t2_vis", 32'(sword_visible), 32'h0);
    check_output("atk_t2_busy", 32'(busy), 32'h1);
    press_tick(B_RIGHT);
    check_output("atk_t3_busy", 32'(busy), 32'h0);
    press_tick(5'b0);
    check_output("busy_ignored_pos", 32'(player_pos), 32'h35);
    check_output("busy_ignored_orient", 32'(player_orientation), 32'h3);

    press_tick(B_ATK);
    check_output("atk2_vis", 32'(sword_visible), 32'h1);
    apply_stimulus(1'b1, 5'b0, 1'b0, 1'b1);
    check_output("respawn_pos", 32'(player_pos), 32'h13);
    check_output("respawn_vis", 32'(sword_visible), 32'h0);
    check_output("respawn_busy", 32'(busy), 32'h0);
    check_output("respawn_dir", 32'(player_direction), 32'h3);

    apply_stimulus(1'b0, B_DOWN, 1'b0, 1'b0);
    for (int t = 0; t < 17; t++) begin
      for (int k = 0; k < 3; k++) apply_stimulus(1'b0, B_DOWN, 1'b0, 1'b0);
      apply_stimulus(1'b1, B_DOWN, 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 5'b0, 1'b0, 1'b0);
    check_output("hold_down_pos", 32'(player_pos), 32'(AR_END));

    apply_stimulus(1'b0, B_UP, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5'b0, 1'b1, 1'b0);
    check_output("frozen_pos", 32'(player_pos), 32'(AR_END));
    apply_stimulus(1'b0, 5'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 5'b0, 1'b0, 1'b0);
    check_output("unfrozen_pos", 32'(player_pos), 32'(AR_END));

    press_tick(B_LEFT);
    press_tick(B_ATK);
    check_output("offgrid_vis", 32'(sword_visible), 32'h0);
    check_output("offgrid_busy", 32'(busy), 32'h1);
    check_output("offgrid_sword_pos", 32'(sword_position), 32'(8'hF0 | (AR_END & 8'h0F)));
    for (int i = 0; i < 3; i++) press_tick(5'b0);

    rb = 5'b0;
    rf = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) rb = 5'($urandom & $urandom);
      if ($urandom_range(0, 39) == 0) rf = ~rf;
      reset = ($urandom_range(0, 999) != 0);
      apply_stimulus(($urandom_range(0, 3) == 0), rb, rf, ($urandom_range(0, 199) == 0));
    end
    reset = 1'b1;
    apply_stimulus(1'b0, 5'b0, 1'b0, 1'b0);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
